// File: rtl/rf_port_sequencer.sv
// Single-port register file sequencer: arbitrates write-back, two-cycle operand
// fetch and debug access so that at most one register-file access occurs per cycle.
module rf_port_sequencer #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [WIDTH-1:0]      rf_data,
    input  logic [WIDTH-1:0]      rf_value,
    input  logic                  rd_req,
    input  logic                  rd_two,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_ack,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  wb_ack,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0]      dbg_wdata,
    output logic [WIDTH-1:0]      dbg_rdata,
    output logic                  dbg_ack,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        RD_B
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rd_ack_q, wb_ack_q, dbg_ack_q;
    logic [WIDTH-1:0]  op_a_q, op_b_q, dbg_rdata_q;

    logic wb_elig, rd_elig, dbg_elig, starve_win;
    logic gnt_wb, gnt_rd, gnt_dbg;

    // A requester whose ack is currently high is still holding req from the
    // access just completed, so it must not be granted again this cycle.
    // Grants are also held off during reset so the port drives nothing.
    always_comb begin
        wb_elig    = wb_req  & ~wb_ack_q;
        rd_elig    = rd_req  & ~rd_ack_q;
        dbg_elig   = dbg_req & ~dbg_ack_q;
        starve_win = dbg_elig && (starve_cnt_q == CNT_MAX);
        gnt_wb     = 1'b0;
        gnt_rd     = 1'b0;
        gnt_dbg    = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (starve_win)    gnt_dbg = 1'b1;
            else if (wb_elig)  gnt_wb  = 1'b1;
            else if (rd_elig)  gnt_rd  = 1'b1;
            else if (dbg_elig) gnt_dbg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_rd && rd_two) state_d = RD_B;
            RD_B:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (state_q == RD_B && rst_n) begin
            rf_addr = rd_addr_b;
        end else if (gnt_wb) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (gnt_rd) begin
            rf_addr = rd_addr_a;
        end else if (gnt_dbg) begin
            rf_we   = dbg_we;
            rf_addr = dbg_addr;
            rf_data = dbg_we ? dbg_wdata : '0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dbg_req || gnt_dbg)
            starve_cnt_d = '0;
        else if ((gnt_wb || gnt_rd) && (starve_cnt_q < CNT_MAX))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rd_ack_q     <= 1'b0;
            wb_ack_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_ack_q     <= (gnt_rd && !rd_two) || (state_q == RD_B);
            wb_ack_q     <= gnt_wb;
            dbg_ack_q    <= gnt_dbg;
            if (gnt_rd)              op_a_q      <= rf_value;
            if (state_q == RD_B)     op_b_q      <= rf_value;
            if (gnt_dbg && !dbg_we)  dbg_rdata_q <= rf_value;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign wb_ack    = wb_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
